// File: rtl/touch_spi_responder.sv
// XPT2046-style touch controller emulated as an SPI mode-0 slave, oversampled on FAB_CLK.
// Optional build macro TOUCH_AVG_EN turns each snapshot into a rounded running average.
module touch_spi_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int FRAME_BITS  = 24
) (
  input  logic        FAB_CLK,
  input  logic        FAB_RESET,
  input  logic        SPI_SCLK,
  input  logic        SPI_SS_N,
  input  logic        SPI_MOSI,
  output logic        SPI_MISO,
  output logic        SPI_MISO_OE,
  input  logic        SAMPLE_VALID,
  input  logic [11:0] X_POS,
  input  logic [11:0] Y_POS,
  input  logic [11:0] Z1_VAL,
  input  logic [11:0] Z2_VAL,
  input  logic        TOUCHED,
  output logic        PENIRQ_N,
  output logic        CMD_VALID,
  output logic [7:0]  CMD_BYTE,
  output logic [1:0]  DBG_STATE
);
  localparam int CW = $clog2(FRAME_BITS + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, CMD = 2'd1, DATA = 2'd2, IGNORE = 2'd3} state_t;
  state_t state_q;

  logic [SYNC_STAGES-1:0] sclk_sync_q, ss_sync_q, mosi_sync_q, fill_q;
  logic              sclk_prev_q, ss_prev_q;
  logic              sclk_s, ss_s, mosi_s, sclk_rise, sclk_fall, ss_fall;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [6:0]        cmd_sr_q;
  logic [7:0]        cmd_d, cmd_byte_q;
  logic [11:0]       x_q, y_q, z1_q, z2_q, resp_q, resp_d;
  logic              mode8_q, pen_en_q, miso_q, miso_d, oe_q, penirq_n_q, cmd_valid_q;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign ss_s      = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  // SAMPLE_VALID and CMD_VALID are single-cycle strobes with no back-pressure.
  assign ss_fall   = ~ss_s & ss_prev_q;
  assign cmd_d     = {cmd_sr_q, mosi_s};
  assign cnt_d     = (cnt_q == CW'(FRAME_BITS)) ? cnt_q : cnt_q + CW'(1);

  always_comb begin
    resp_d = 12'h000;
    case (cmd_d[6:4])
      3'b001:  resp_d = y_q;
      3'b101:  resp_d = x_q;
      3'b011:  resp_d = z1_q;
      3'b100:  resp_d = z2_q;
      default: resp_d = 12'h000;
    endcase
  end

  // Bit to present for the next rising edge: rising r in 10..21 carries resp[21-r].
  always_comb begin
    miso_d = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if ((int'(cnt_q) + 1 == 21 - i) && (!mode8_q || i >= 4)) miso_d = resp_q[i];
    end
  end

`ifdef TOUCH_AVG_EN
  logic snap_loaded_q;

  function automatic logic [11:0] avg12(input logic [11:0] a, input logic [11:0] b);
    logic [12:0] s;
    s = {1'b0, a} + {1'b0, b} + 13'd1;
    return s[12:1];
  endfunction

  always_ff @(posedge FAB_CLK) begin
    if (FAB_RESET) begin
      snap_loaded_q <= 1'b0;
      x_q <= '0; y_q <= '0; z1_q <= '0; z2_q <= '0;
    end else if (SAMPLE_VALID) begin
      snap_loaded_q <= 1'b1;
      x_q  <= snap_loaded_q ? avg12(x_q, X_POS)   : X_POS;
      y_q  <= snap_loaded_q ? avg12(y_q, Y_POS)   : Y_POS;
      z1_q <= snap_loaded_q ? avg12(z1_q, Z1_VAL) : Z1_VAL;
      z2_q <= snap_loaded_q ? avg12(z2_q, Z2_VAL) : Z2_VAL;
    end
  end
`else
  always_ff @(posedge FAB_CLK) begin
    if (FAB_RESET) begin
      x_q <= '0; y_q <= '0; z1_q <= '0; z2_q <= '0;
    end else if (SAMPLE_VALID) begin
      x_q <= X_POS; y_q <= Y_POS; z1_q <= Z1_VAL; z2_q <= Z2_VAL;
    end
  end
`endif

  always_ff @(posedge FAB_CLK) begin
    if (FAB_RESET) begin
      sclk_sync_q <= '0;
      ss_sync_q   <= '1;
      mosi_sync_q <= '0;
      fill_q      <= '0;
      sclk_prev_q <= 1'b0;
      ss_prev_q   <= 1'b0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      cmd_sr_q    <= '0;
      cmd_byte_q  <= 8'h00;
      cmd_valid_q <= 1'b0;
      resp_q      <= '0;
      mode8_q     <= 1'b0;
      pen_en_q    <= 1'b1;
      miso_q      <= 1'b0;
      oe_q        <= 1'b0;
      penirq_n_q  <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SPI_SCLK};
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], SPI_SS_N};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], SPI_MOSI};
      fill_q      <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      sclk_prev_q <= sclk_s;
      // Until the chain holds real samples SS_N is not trusted, so a select held low
      // across reset never looks like a fresh falling edge.
      ss_prev_q   <= fill_q[SYNC_STAGES-1] ? ss_s : 1'b0;
      cmd_valid_q <= 1'b0;
      oe_q        <= ~ss_s;
      penirq_n_q  <= ~(TOUCHED & pen_en_q & ss_s);
      if (ss_s) begin
        state_q  <= IDLE;
        cnt_q    <= '0;
        cmd_sr_q <= '0;
        miso_q   <= 1'b0;
      end else begin
        case (state_q)
          IDLE: if (ss_fall) begin
            state_q <= CMD;
            cnt_q   <= '0;
          end
          CMD: if (sclk_rise) begin
            cnt_q    <= cnt_d;
            cmd_sr_q <= cmd_d[6:0];
            if (cnt_q == CW'(7)) begin
              if (cmd_d[7]) begin
                cmd_byte_q  <= cmd_d;
                cmd_valid_q <= 1'b1;
                resp_q      <= resp_d;
                mode8_q     <= cmd_d[3];
                pen_en_q    <= (cmd_d[1:0] == 2'b00);
                state_q     <= DATA;
              end else begin
                state_q <= IGNORE;
              end
            end
          end
          DATA: begin
            if (sclk_rise) cnt_q <= cnt_d;
            if (sclk_fall) miso_q <= miso_d;
          end
          default: begin
            if (sclk_rise) cnt_q <= cnt_d;
            miso_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign SPI_MISO    = miso_q;
  assign SPI_MISO_OE = oe_q;
  assign PENIRQ_N    = penirq_n_q;
  assign CMD_VALID   = cmd_valid_q;
  assign CMD_BYTE    = cmd_byte_q;
  assign DBG_STATE   = state_q;
endmodule

// File: tb/tb_touch_spi_responder.sv
// Bench for touch_spi_responder: directed scenarios plus random frames against a word-level model.
module tb_touch_spi_responder;
  logic        FAB_CLK = 1'b0;
  logic        FAB_RESET, SPI_SCLK, SPI_SS_N, SPI_MOSI, SAMPLE_VALID, TOUCHED;
  logic [11:0] X_POS, Y_POS, Z1_VAL, Z2_VAL;
  logic        SPI_MISO, SPI_MISO_OE, PENIRQ_N, CMD_VALID;
  logic [7:0]  CMD_BYTE;
  logic [1:0]  DBG_STATE;

  int checks = 0;
  int failures = 0;
  int cv_cnt = 0;
  logic [11:0] m_x, m_y, m_z1, m_z2;
  logic        m_loaded;
  logic [7:0]  m_cmd_byte;
  logic        oe_seen;

`ifdef TOUCH_AVG_EN
  localparam bit AVG_EN = 1'b1;
`else
  localparam bit AVG_EN = 1'b0;
`endif

  touch_spi_responder dut (
    .FAB_CLK(FAB_CLK), .FAB_RESET(FAB_RESET), .SPI_SCLK(SPI_SCLK), .SPI_SS_N(SPI_SS_N),
    .SPI_MOSI(SPI_MOSI), .SPI_MISO(SPI_MISO), .SPI_MISO_OE(SPI_MISO_OE),
    .SAMPLE_VALID(SAMPLE_VALID), .X_POS(X_POS), .Y_POS(Y_POS), .Z1_VAL(Z1_VAL),
    .Z2_VAL(Z2_VAL), .TOUCHED(TOUCHED), .PENIRQ_N(PENIRQ_N), .CMD_VALID(CMD_VALID),
    .CMD_BYTE(CMD_BYTE), .DBG_STATE(DBG_STATE)
  );

  // Clock / reset
  always #5 FAB_CLK = ~FAB_CLK;

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  always @(negedge FAB_CLK) if (!FAB_RESET && CMD_VALID === 1'b1) cv_cnt++;

  // Reference model
  function automatic logic [11:0] m_upd(input logic [11:0] old, input logic [11:0] nw,
                                        input logic loaded);
    int avg;
    avg = (int'(old) + int'(nw) + 1) / 2;
    if (AVG_EN && loaded) return avg[11:0];
    return nw;
  endfunction

  // Bits the master sees at rising edges 1..32 (leftmost = rising 1).
  function automatic logic [1:32] m_expect(input logic [7:0] cmd);
    logic [11:0] w;
    case (cmd[6:4])
      3'b001:  w = m_y;
      3'b101:  w = m_x;
      3'b011:  w = m_z1;
      3'b100:  w = m_z2;
      default: w = 12'h000;
    endcase
    if (!cmd[7]) return '0;
    if (cmd[3]) return {9'b0, w[11:4], 15'b0};
    return {9'b0, w, 11'b0};
  endfunction

  task automatic model_clear();
    m_x = '0; m_y = '0; m_z1 = '0; m_z2 = '0;
    m_loaded = 1'b0;
    m_cmd_byte = 8'h00;
  endtask

  // Driver tasks
  task automatic do_reset();
    @(negedge FAB_CLK);
    FAB_RESET = 1'b1; SPI_SS_N = 1'b1; SPI_SCLK = 1'b0; SPI_MOSI = 1'b0; SAMPLE_VALID = 1'b0;
    repeat (3) @(negedge FAB_CLK);
    FAB_RESET = 1'b0;
    model_clear();
  endtask

  task automatic pulse_sample();
    @(negedge FAB_CLK);
    SAMPLE_VALID = 1'b1;
    m_x  = m_upd(m_x, X_POS, m_loaded);
    m_y  = m_upd(m_y, Y_POS, m_loaded);
    m_z1 = m_upd(m_z1, Z1_VAL, m_loaded);
    m_z2 = m_upd(m_z2, Z2_VAL, m_loaded);
    m_loaded = 1'b1;
    @(negedge FAB_CLK);
    SAMPLE_VALID = 1'b0;
  endtask

  task automatic load_sample(input logic [11:0] x, input logic [11:0] y,
                             input logic [11:0] z1, input logic [11:0] z2);
    @(negedge FAB_CLK);
    X_POS = x; Y_POS = y; Z1_VAL = z1; Z2_VAL = z2;
    pulse_sample();
  endtask

  // One SS_N-framed transfer of nclk SCLK periods (16 FAB_CLK each); optional mid-frame
  // sample strobe (new X) or FAB_RESET pulse after the given rising edge.
  task automatic spi_frame(input logic [7:0] cmd, input int nclk, input int strobe_at,
                           input logic [11:0] strobe_x, input int reset_at,
                           output logic [1:32] bits);
    bits = '0;
    oe_seen = 1'b0;
    @(negedge FAB_CLK);
    SPI_SS_N = 1'b0;
    repeat (8) @(negedge FAB_CLK);
    for (int r = 1; r <= nclk; r++) begin
      SPI_MOSI = (r <= 8) ? cmd[8-r] : 1'($urandom_range(0, 1));
      repeat (8) @(negedge FAB_CLK);
      bits[r] = SPI_MISO;
      if (r == 1) oe_seen = SPI_MISO_OE;
      SPI_SCLK = 1'b1;
      if (r == strobe_at) begin
        X_POS = strobe_x;
        pulse_sample();
      end
      if (r == reset_at) begin
        FAB_RESET = 1'b1;
        repeat (2) @(negedge FAB_CLK);
        FAB_RESET = 1'b0;
        model_clear();
      end
      repeat (8) @(negedge FAB_CLK);
      SPI_SCLK = 1'b0;
    end
    repeat (8) @(negedge FAB_CLK);
    SPI_SS_N = 1'b1;
    repeat (10) @(negedge FAB_CLK);
  endtask

  // Tests
  task automatic test_reset();
    logic [1:32] got;
    TOUCHED = 1'b0; X_POS = '0; Y_POS = '0; Z1_VAL = '0; Z2_VAL = '0;
    do_reset();
    checks++; if (SPI_MISO !== 1'b0) begin failures++; $display("FAIL reset_miso got=%b exp=0", SPI_MISO); end
    checks++; if (SPI_MISO_OE !== 1'b0) begin failures++; $display("FAIL reset_oe got=%b exp=0", SPI_MISO_OE); end
    checks++; if (PENIRQ_N !== 1'b1) begin failures++; $display("FAIL reset_penirq got=%b exp=1", PENIRQ_N); end
    checks++; if (CMD_VALID !== 1'b0) begin failures++; $display("FAIL reset_cmd_valid got=%b exp=0", CMD_VALID); end
    checks++; if (CMD_BYTE !== 8'h00) begin failures++; $display("FAIL reset_cmd_byte got=%h exp=00", CMD_BYTE); end
    checks++; if (DBG_STATE !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", DBG_STATE); end
    spi_frame(8'hD0, 24, 0, 12'h0, 0, got);
    m_cmd_byte = 8'hD0;
    checks++; if (got !== '0) begin failures++; $display("FAIL reset_snapshot_zero got=%h exp=0", got); end
  endtask

  task automatic test_x_read();
    logic [1:32] got, exp;
    int cv0;
    load_sample(12'hA5C, 12'($urandom), 12'($urandom), 12'($urandom));
    exp = m_expect(8'hD0);
    cv0 = cv_cnt;
    spi_frame(8'hD0, 24, 0, 12'h0, 0, got);
    m_cmd_byte = 8'hD0;
    checks++; if (got !== exp) begin failures++; $display("FAIL x_read_bits got=%h exp=%h", got, exp); end
    checks++; if (cv_cnt - cv0 != 1) begin failures++; $display("FAIL x_read_cmd_valid got=%0d exp=1", cv_cnt - cv0); end
    checks++; if (CMD_BYTE !== 8'hD0) begin failures++; $display("FAIL x_read_cmd_byte got=%h exp=d0", CMD_BYTE); end
    checks++; if (oe_seen !== 1'b1) begin failures++; $display("FAIL x_read_oe_active got=%b exp=1", oe_seen); end
    checks++; if (SPI_MISO_OE !== 1'b0 || DBG_STATE !== 2'd0) begin
      failures++; $display("FAIL x_read_end_idle oe=%b state=%0d exp oe=0 state=0", SPI_MISO_OE, DBG_STATE);
    end
  endtask

  task automatic test_8bit();
    logic [1:32] got, exp;
    load_sample(12'($urandom), 12'h3F7, 12'($urandom), 12'($urandom));
    exp = m_expect(8'h98);
    spi_frame(8'h98, 24, 0, 12'h0, 0, got);
    m_cmd_byte = 8'h98;
    checks++; if (got !== exp) begin failures++; $display("FAIL mode8_bits got=%h exp=%h", got, exp); end
    checks++; if (CMD_BYTE !== 8'h98) begin failures++; $display("FAIL mode8_cmd_byte got=%h exp=98", CMD_BYTE); end
  endtask

  task automatic test_invalid_start();
    logic [1:32] got;
    int cv0;
    cv0 = cv_cnt;
    spi_frame(8'h50, 24, 0, 12'h0, 0, got);
    checks++; if (got !== '0) begin failures++; $display("FAIL invalid_bits got=%h exp=0", got); end
    checks++; if (cv_cnt != cv0) begin failures++; $display("FAIL invalid_cmd_valid got=%0d exp=0", cv_cnt - cv0); end
    checks++; if (CMD_BYTE !== m_cmd_byte) begin failures++; $display("FAIL invalid_cmd_byte got=%h exp=%h", CMD_BYTE, m_cmd_byte); end
  endtask

  task automatic test_abort();
    logic [1:32] got, exp;
    int cv0;
    load_sample(12'($urandom), 12'($urandom), 12'h123, 12'($urandom));
    cv0 = cv_cnt;
    spi_frame(8'hB0, 5, 0, 12'h0, 0, got);
    checks++; if (cv_cnt != cv0) begin failures++; $display("FAIL abort_cmd_valid got=%0d exp=0", cv_cnt - cv0); end
    checks++; if (CMD_BYTE !== m_cmd_byte) begin failures++; $display("FAIL abort_cmd_byte got=%h exp=%h", CMD_BYTE, m_cmd_byte); end
    exp = m_expect(8'hB0);
    spi_frame(8'hB0, 24, 0, 12'h0, 0, got);
    m_cmd_byte = 8'hB0;
    checks++; if (got !== exp) begin failures++; $display("FAIL abort_next_bits got=%h exp=%h", got, exp); end
    checks++; if (cv_cnt - cv0 != 1) begin failures++; $display("FAIL abort_next_cmd_valid got=%0d exp=1", cv_cnt - cv0); end
  endtask

  task automatic test_coherence();
    logic [1:32] got, exp;
    load_sample(12'h0F0, Y_POS, Z1_VAL, Z2_VAL);
    exp = m_expect(8'hD0);
    spi_frame(8'hD0, 24, 12, 12'h111, 0, got);
    checks++; if (got !== exp) begin failures++; $display("FAIL coherence_cur_bits got=%h exp=%h", got, exp); end
    exp = m_expect(8'hD0);
    spi_frame(8'hD0, 24, 0, 12'h0, 0, got);
    m_cmd_byte = 8'hD0;
    checks++; if (got !== exp) begin failures++; $display("FAIL coherence_next_bits got=%h exp=%h", got, exp); end
  endtask

  task automatic test_overrun();
    logic [1:32] got, exp;
    int cv0;
    load_sample(12'($urandom), 12'($urandom), 12'($urandom), 12'($urandom));
    exp = m_expect(8'hD3);
    cv0 = cv_cnt;
    spi_frame(8'hD3, 32, 0, 12'h0, 0, got);
    m_cmd_byte = 8'hD3;
    checks++; if (got !== exp) begin failures++; $display("FAIL overrun_bits got=%h exp=%h", got, exp); end
    checks++; if (cv_cnt - cv0 != 1) begin failures++; $display("FAIL overrun_cmd_valid got=%0d exp=1", cv_cnt - cv0); end
  endtask

  task automatic test_mid_frame_reset();
    logic [1:32] got, exp;
    int cv0;
    load_sample(12'($urandom), 12'($urandom), 12'($urandom), 12'($urandom));
    cv0 = cv_cnt;
    spi_frame(8'hD0, 24, 0, 12'h0, 4, got);
    checks++; if (got !== '0) begin failures++; $display("FAIL midreset_bits got=%h exp=0", got); end
    checks++; if (cv_cnt != cv0 || CMD_BYTE !== 8'h00) begin
      failures++; $display("FAIL midreset_no_cmd pulses=%0d byte=%h exp 0 and 00", cv_cnt - cv0, CMD_BYTE);
    end
    load_sample(12'($urandom), 12'($urandom), 12'($urandom), 12'($urandom));
    exp = m_expect(8'hD0);
    spi_frame(8'hD0, 24, 0, 12'h0, 0, got);
    m_cmd_byte = 8'hD0;
    checks++; if (got !== exp) begin failures++; $display("FAIL midreset_restart_bits got=%h exp=%h", got, exp); end
  endtask

  task automatic test_pen_irq();
    logic [1:32] got;
    do_reset();
    TOUCHED = 1'b1;
    repeat (5) @(negedge FAB_CLK);
    checks++; if (PENIRQ_N !== 1'b0) begin failures++; $display("FAIL pen_idle got=%b exp=0", PENIRQ_N); end
    SPI_SS_N = 1'b0;
    repeat (6) @(negedge FAB_CLK);
    checks++; if (PENIRQ_N !== 1'b1) begin failures++; $display("FAIL pen_in_frame got=%b exp=1", PENIRQ_N); end
    SPI_SS_N = 1'b1;
    repeat (6) @(negedge FAB_CLK);
    checks++; if (PENIRQ_N !== 1'b0) begin failures++; $display("FAIL pen_after_frame got=%b exp=0", PENIRQ_N); end
    spi_frame(8'hD1, 24, 0, 12'h0, 0, got);
    repeat (6) @(negedge FAB_CLK);
    checks++; if (PENIRQ_N !== 1'b1) begin failures++; $display("FAIL pen_disabled got=%b exp=1", PENIRQ_N); end
    do_reset();
    repeat (5) @(negedge FAB_CLK);
    checks++; if (PENIRQ_N !== 1'b0) begin failures++; $display("FAIL pen_after_reset got=%b exp=0", PENIRQ_N); end
    TOUCHED = 1'b0;
    repeat (3) @(negedge FAB_CLK);
    checks++; if (PENIRQ_N !== 1'b1) begin failures++; $display("FAIL pen_untouched got=%b exp=1", PENIRQ_N); end
  endtask

  task automatic test_random();
    logic [1:32] got, exp;
    logic [7:0] cmd;
    int cv0;
    for (int n = 0; n < 12; n++) begin
      load_sample(12'($urandom), 12'($urandom), 12'($urandom), 12'($urandom));
      cmd = 8'($urandom);
      exp = m_expect(cmd);
      cv0 = cv_cnt;
      spi_frame(cmd, 24, 0, 12'h0, 0, got);
      if (cmd[7]) m_cmd_byte = cmd;
      checks++; if (got !== exp) begin failures++; $display("FAIL rand_bits cmd=%h got=%h exp=%h", cmd, got, exp); end
      checks++; if (cv_cnt - cv0 != int'(cmd[7])) begin failures++; $display("FAIL rand_cmd_valid cmd=%h got=%0d exp=%0d", cmd, cv_cnt - cv0, cmd[7]); end
      checks++; if (CMD_BYTE !== m_cmd_byte) begin failures++; $display("FAIL rand_cmd_byte got=%h exp=%h", CMD_BYTE, m_cmd_byte); end
    end
  endtask

  initial begin
    FAB_RESET = 1'b1; SPI_SCLK = 1'b0; SPI_SS_N = 1'b1; SPI_MOSI = 1'b0;
    SAMPLE_VALID = 1'b0; TOUCHED = 1'b0;
    X_POS = '0; Y_POS = '0; Z1_VAL = '0; Z2_VAL = '0;
    model_clear();
    test_reset();
    test_x_read();
    test_8bit();
    test_invalid_start();
    test_abort();
    test_coherence();
    test_overrun();
    test_mid_frame_reset();
    test_pen_irq();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/touch_spi_responder.md
Name: touch_spi_responder

Overview:
- Fabric-side SPI slave emulating an XPT2046-style resistive touch controller, so the MSS SPI_1 master can be exercised against fabric-generated touch samples.
- Oversamples SPI_1 CLK/SS/DO in the FAB_CLK domain.
- Decodes the 8-bit control byte and returns a 12-bit (or 8-bit) sample on MISO in the same frame.
- Sample registers are loaded from fabric coordinate inputs.

Parameters:
- SYNC_STAGES, 2, synchroniser depth on SCLK/SS_N/MOSI (legal range 2..3).
- FRAME_BITS, 24, SCLK rising edges per full frame; the bit counter saturates here.

Ports:
- FAB_CLK  input  1  fabric clock; must be >= 8x SCLK.
- FAB_RESET  input  1  synchronous, active-high reset.
- SPI_SCLK  input  1  SPI clock from master, mode 0 (CPOL=0, CPHA=0).
- SPI_SS_N  input  1  active-low slave select.
- SPI_MOSI  input  1  master data out.
- SPI_MISO  output  1  slave data to master.
- SPI_MISO_OE  output  1  MISO drive enable (1 while synced SS_N low).
- SAMPLE_VALID  input  1  1-cycle strobe; loads X/Y/Z1/Z2 snapshot.
- X_POS  input  12  X sample.
- Y_POS  input  12  Y sample.
- Z1_VAL  input  12  pressure Z1.
- Z2_VAL  input  12  pressure Z2.
- TOUCHED  input  1  pen-down indication.
- PENIRQ_N  output  1  active-low pen interrupt.
- CMD_VALID  output  1  1-cycle pulse when a valid command byte has been received.
- CMD_BYTE  output  8  last valid command byte.

Behaviour:
- Reset values: SPI_MISO=0, SPI_MISO_OE=0, PENIRQ_N=1, CMD_VALID=0, CMD_BYTE=8'h00, snapshots=0, bit counter=0, pen-irq enable=1, state=IDLE.
- Synchronisation: SCLK, SS_N and MOSI each pass through SYNC_STAGES flops. Edges are detected on the synced SCLK, so edge-to-action latency is SYNC_STAGES+1 FAB_CLK cycles.
- Snapshot: on SAMPLE_VALID, X/Y/Z1/Z2 are registered into snapshots. A strobe during a frame updates the snapshot but not the already-latched response word.
- States:
  - IDLE: synced SS_N high. Go to CMD on SS_N falling.
  - CMD: shift MOSI MSB-first on rising edges 1..8.
    - At rising edge 8, if bit7 (start) = 1: CMD_BYTE<=byte, pulse CMD_VALID, latch the response word, go to DATA.
    - If bit7 = 0: go to IGNORE.
  - DATA: MISO is updated on SCLK falling edges only.
    - Value seen at rising edge 9 is 0 (busy/null).
    - Rising 10..21 see D11..D0.
    - In MODE=1 (bit3, 8-bit), rising 10..17 see D11..D4 and later bits are 0.
    - After the last data bit, MISO=0.
  - IGNORE: MISO=0 until SS_N rises; no CMD_VALID.
- Response word (12-bit) by channel, cmd[6:4]:
  - 001 -> Y snapshot.
  - 101 -> X snapshot.
  - 011 -> Z1 snapshot.
  - 100 -> Z2 snapshot.
  - others -> 12'h000.
- Bit counter: counts SCLK rising edges and saturates at FRAME_BITS. Edges beyond FRAME_BITS keep MISO=0 and do not start a new command. A new command needs SS_N to rise then fall.
- SS_N rising at any point: return to IDLE within SYNC_STAGES+1 cycles, clear the counter, MISO=0, MISO_OE=0. A partial command byte is discarded and CMD_VALID is not pulsed.
- Pen IRQ:
  - Enable = (cmd[1:0]==2'b00), updated at each valid command; the reset value is enabled.
  - PENIRQ_N = ~(TOUCHED & enable & SS_N_synced), registered, so it is forced high during a frame.
- FAB_RESET mid-frame: all state returns to reset values. The frame in progress is abandoned and the next SS_N falling edge is required to restart.

Optional Feature:
- Macro TOUCH_AVG_EN.
- Defined: each snapshot register is updated as (old + new + 1) >> 1 using 13-bit intermediate arithmetic. The first SAMPLE_VALID after reset loads the raw value.
- Undefined: snapshots load raw inputs directly.

Test Plan:
- Basic X read: X_POS=12'hA5C, SAMPLE_VALID pulse; frame with cmd 8'hD0 (ch 101, 12-bit), 24 clocks -> CMD_VALID pulse, CMD_BYTE=8'hD0; bits at rising 10..21 = 1010_0101_1100; rising 9 and 22..24 = 0.
- 8-bit mode: Y_POS=12'h3F7, cmd 8'h98 (ch 001, MODE=1) -> rising 10..17 = 0011_1111; rising 18..24 = 0.
- Invalid start bit: cmd 8'h50 -> no CMD_VALID, MISO=0 entire frame, CMD_BYTE unchanged.
- Abort: SS_N raised after 5 SCLKs, then full frame cmd 8'hB0 with Z1_VAL=12'h123 -> first frame produces no CMD_VALID; second frame returns 12'h123.
- Snapshot coherence: SAMPLE_VALID with X_POS=12'h111 during DATA of an X read that latched 12'h0F0 -> current frame returns 12'h0F0; next frame returns 12'h111.
- Pen IRQ: TOUCHED=1, idle -> PENIRQ_N=0; during frame -> 1; after cmd 8'hD1 (PD=01) -> PENIRQ_N stays 1 with TOUCHED=1; FAB_RESET -> 0 again.
